// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared state encodings, opcodes, ALU codes and flag indices
//               for the multicycle RISC-V controller.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  typedef enum logic [3:0] {
    s_fetch    = 4'd0,
    s_decode   = 4'd1,
    s_memadr   = 4'd2,
    s_memread  = 4'd3,
    s_memwb    = 4'd4,
    s_memwrite = 4'd5,
    s_executer = 4'd6,
    s_executei = 4'd7,
    s_aluwb    = 4'd8,
    s_jal      = 4'd9,
    s_branch   = 4'd10
  } state_t;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  localparam logic [1:0] c_aluop_add  = 2'b00;
  localparam logic [1:0] c_aluop_sub  = 2'b01;
  localparam logic [1:0] c_aluop_func = 2'b10;

  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_slt = 3'b101;

  // Flags bus is {N,Z,C,V}
  localparam int c_flag_n = 3;
  localparam int c_flag_z = 2;
  localparam int c_flag_c = 1;
  localparam int c_flag_v = 0;

endpackage
`default_nettype wire

// File: rtl/alu_dec.sv
`default_nettype none
// ============================================================================
// Module      : alu_dec
// Description : Combinational ALUOp/funct3/funct7b5 -> ALUCtrl decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_dec
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = c_alu_add;
    case (aluop)
      c_aluop_add: alu_ctrl = c_alu_add;
      c_aluop_sub: alu_ctrl = c_alu_sub;
      c_aluop_func: begin
        case (funct3)
          // only R-type (op[5]=1) may select sub; addi ignores bit 30
          3'b000:  alu_ctrl = (op5 & funct7b5) ? c_alu_sub : c_alu_add;
          3'b010:  alu_ctrl = c_alu_slt;
          3'b110:  alu_ctrl = c_alu_or;
          3'b111:  alu_ctrl = c_alu_and;
          default: alu_ctrl = c_alu_add;
        endcase
      end
      default: alu_ctrl = c_alu_add;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Moore-style multicycle RISC-V main controller FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] Flags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtrl,
  output logic [1:0] ImmSrc,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t     r_state;
  state_t     w_next;
  logic       w_pcupdate;
  logic       w_branch;
  logic       w_take;
  logic [1:0] w_aluop;
  logic       w_unused_carry;

  assign w_unused_carry = Flags[c_flag_c];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= s_fetch;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = s_fetch;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    w_aluop    = c_aluop_add;
    w_pcupdate = 1'b0;
    w_branch   = 1'b0;
    Illegal    = 1'b0;
    case (r_state)
      s_fetch: begin
        IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        w_pcupdate = 1'b1;
        w_next = s_decode;
      end
      s_decode: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        case (op)
          c_op_load, c_op_store: w_next = s_memadr;
          c_op_rtype:            w_next = s_executer;
          c_op_itype:            w_next = s_executei;
          c_op_jal:              w_next = s_jal;
          c_op_branch:           w_next = s_branch;
          default: begin
            w_next  = s_fetch;
            Illegal = 1'b1;
          end
        endcase
      end
      s_memadr: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        w_next = (op == c_op_load) ? s_memread : s_memwrite;
      end
      s_memread: begin
        AdrSrc = 1'b1;
        w_next = s_memwb;
      end
      s_memwb: begin
        ResultSrc = 2'b01; RegWrite = 1'b1;
        w_next = s_fetch;
      end
      s_memwrite: begin
        AdrSrc = 1'b1; MemWrite = 1'b1;
        w_next = s_fetch;
      end
      s_executer: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b00; w_aluop = c_aluop_func;
        w_next = s_aluwb;
      end
      s_executei: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; w_aluop = c_aluop_func;
        w_next = s_aluwb;
      end
      s_aluwb: begin
        RegWrite = 1'b1;
        w_next = s_fetch;
      end
      s_jal: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; w_pcupdate = 1'b1;
        w_next = s_aluwb;
      end
      s_branch: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b00; w_aluop = c_aluop_sub;
        w_branch = 1'b1;
        w_next = s_fetch;
      end
      default: w_next = s_fetch;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  w_take = Flags[c_flag_z];
      3'b001:  w_take = ~Flags[c_flag_z];
      3'b100:  w_take = Flags[c_flag_n] ^ Flags[c_flag_v];
      3'b101:  w_take = ~(Flags[c_flag_n] ^ Flags[c_flag_v]);
      default: w_take = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      c_op_store:  ImmSrc = 2'b01;
      c_op_branch: ImmSrc = 2'b10;
      c_op_jal:    ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  assign PCWrite = w_pcupdate | (w_branch & w_take);
  assign State   = r_state;

  alu_dec u_alu_dec (
    .aluop    (w_aluop),
    .funct3   (funct3),
    .op5      (op[5]),
    .funct7b5 (funct7b5),
    .alu_ctrl (ALUCtrl)
  );

endmodule
`default_nettype wire
